// File: rtl/fifo_stage_ctrl.sv
// rtl/fifo_stage_ctrl.sv - credit-guarded sequencer between an upstream FIFO, a fixed-latency datapath and a downstream FIFO
module fifo_stage_ctrl #(
  parameter int FRAME_PIXELS   = 8,
  parameter int PIPE_LATENCY   = 3,
  parameter int OUT_FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1),
  localparam int CRD_W = $clog2(OUT_FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_empty,
  output logic             in_rd_en,
  input  logic             out_full,
  output logic             out_wr_en,
  input  logic             credit_return,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pixel_count,
  output logic             credit_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CRD_W-1:0] CRD_FULL  = CRD_W'(OUT_FIFO_DEPTH);

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [CNT_W-1:0]        issued;
  logic [CRD_W-1:0]        credits;
  logic [PIPE_LATENCY-1:0] valid_pipe;

  // Issue only while a downstream slot is reserved for the result, so
  // in-flight pixels can never overrun the output FIFO.
  assign in_rd_en  = (state == S_RUN) && !in_empty && (credits != '0) && (issued < FRAME_CNT);
  assign out_wr_en = valid_pipe[PIPE_LATENCY-1];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (in_rd_en && (issued == LAST_CNT)) state_nxt = S_DRAIN;
      S_DRAIN: if (pixel_count == FRAME_CNT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      issued      <= '0;
      pixel_count <= '0;
      credits     <= CRD_FULL;
      valid_pipe  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      credit_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done       <= (state_nxt == S_DONE);
      valid_pipe <= (valid_pipe << 1) | PIPE_LATENCY'(in_rd_en);

      if ((state == S_IDLE) && start) begin
        issued      <= '0;
        pixel_count <= '0;
      end else begin
        if (in_rd_en) issued <= issued + 1'b1;
        if (out_wr_en && (pixel_count != FRAME_CNT)) pixel_count <= pixel_count + 1'b1;
      end

      // A return with no outstanding words means the consumer and this
      // block disagree about FIFO occupancy; flag it rather than overflow.
      if (in_rd_en && !credit_return) begin
        credits <= credits - 1'b1;
      end else if (!in_rd_en && credit_return) begin
        if (credits == CRD_FULL) credit_err <= 1'b1;
        else                     credits    <= credits + 1'b1;
      end

      if (out_wr_en && out_full) credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stage_ctrl.sv
// tb/tb_fifo_stage_ctrl.sv - randomized and directed checks of fifo_stage_ctrl against a queue-based reference model
module tb_fifo_stage_ctrl;

  localparam int FP = 8;
  localparam int PL = 3;
  localparam int D  = 4;

  logic       clock = 1'b0;
  logic       reset, start, in_empty, out_full, credit_return;
  logic       in_rd_en, out_wr_en, busy, done, credit_err;
  logic [3:0] pixel_count;

  always #5 clock = ~clock;

  fifo_stage_ctrl #(.FRAME_PIXELS(FP), .PIPE_LATENCY(PL), .OUT_FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .start(start), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_full(out_full), .out_wr_en(out_wr_en),
    .credit_return(credit_return), .busy(busy), .done(done),
    .pixel_count(pixel_count), .credit_err(credit_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a frame is "running" from start until all pixels are
  // retired; each issue schedules a push PL cycles later in a due-time queue.
  bit m_run = 0, m_done = 0, m_err = 0;
  int m_issued = 0, m_retired = 0, m_credits = D;
  int due[$];
  int cyc = 0;
  int occ = 0;
  int n_rd, n_wr, n_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit e_rd, e_wr, was_run, was_done;
    int ret_old;
    @(negedge clock);
    e_rd = m_run && (m_issued < FP) && !in_empty && (m_credits > 0);
    e_wr = (due.size() > 0) && (due[0] == cyc);
    check("in_rd_en", in_rd_en, e_rd);
    check("out_wr_en", out_wr_en, e_wr);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("pixel_count", pixel_count, m_retired);
    check("credit_err", credit_err, m_err);
    check("credits", dut.credits, m_credits);
    check("rd_while_empty", in_rd_en && in_empty, 0);
    if (in_rd_en) n_rd++;
    if (out_wr_en) n_wr++;
    if (done) n_done++;
    if (reset) begin
      m_run = 0; m_done = 0; m_err = 0;
      m_issued = 0; m_retired = 0; m_credits = D;
      due.delete();
      occ = 0;
    end else begin
      was_run = m_run; was_done = m_done; ret_old = m_retired;
      if (e_wr) begin
        void'(due.pop_front());
        m_retired++;
        if (out_full) m_err = 1;
        occ++;
      end
      if (credit_return && occ > 0) occ--;
      if (e_rd && !credit_return) m_credits--;
      else if (!e_rd && credit_return) begin
        if (m_credits == D) m_err = 1;
        else m_credits++;
      end
      if (e_rd) begin
        m_issued++;
        due.push_back(cyc + PL);
      end
      m_done = 0;
      if (was_run && ret_old == FP) begin
        m_run = 0;
        m_done = 1;
      end
      if (!was_run && !was_done && start) begin
        m_run = 1; m_issued = 0; m_retired = 0;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_done = 0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // rnd_empty: randomize upstream empty; rnd_ret: consumer pops randomly
  // instead of every cycle it has data.
  task automatic run_frame(input bit rnd_empty, input bit rnd_ret);
    for (int i = 0; i < 400; i++) begin
      in_empty      = rnd_empty ? 1'($urandom_range(0, 1)) : 1'b0;
      credit_return = (occ > 0) && (rnd_ret ? 1'($urandom_range(0, 1)) : 1'b1);
      out_full      = (occ >= D);
      tick();
      if (n_done != 0) break;
    end
    credit_return = 1'b0;
    check("frame_finished", n_done != 0, 1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_rd_count"}, n_rd, FP);
    check({tag, "_wr_count"}, n_wr, FP);
    check({tag, "_done_count"}, n_done, 1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_empty = 1'b1; out_full = 1'b0; credit_return = 1'b0;

    // Reset state
    do_reset(2);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", credit_err, 0);
    check("reset_credits", dut.credits, D);

    // Credit stall with no returns, then returns release the remaining issues
    clear_counts();
    in_empty = 1'b0;
    start_frame();
    repeat (12) tick();
    check("stall_rd_count", n_rd, D);
    check("stall_wr_count", n_wr, D);
    check("stall_credits", dut.credits, 0);
    run_frame(0, 0);
    check_frame("stall");
    check("stall_pixels", pixel_count, FP);

    // Random upstream empty, consumer pops after each push
    repeat (D + 2) begin credit_return = (occ > 0); tick(); end
    clear_counts();
    start_frame();
    run_frame(1, 0);
    check_frame("rand_empty");

    // Random upstream and random consumer
    for (int f = 0; f < 3; f++) begin
      clear_counts();
      start_frame();
      run_frame(1, 1);
      check_frame("rand_both");
    end

    // Simultaneous issue and return at credits=1
    do_reset(1);
    in_empty = 1'b0;
    start_frame();
    repeat (3) tick();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("simul_credits", dut.credits, 1);
    check("simul_next_issue", in_rd_en, 1);
    clear_counts();
    run_frame(0, 0);

    // Reset mid-RUN after three issues
    do_reset(1);
    in_empty = 1'b0;
    start_frame();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_rd", in_rd_en, 0);
    check("abort_wr", out_wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_pixels", pixel_count, 0);
    check("abort_credits", dut.credits, D);
    repeat (4) tick();
    clear_counts();
    start_frame();
    run_frame(1, 1);
    check_frame("after_abort");

    // Credit overflow is sticky; start during RUN is ignored
    repeat (20) begin credit_return = (occ > 0); tick(); end
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("overflow_err", credit_err, 1);
    check("overflow_credits", dut.credits, D);
    clear_counts();
    in_empty = 1'b0;
    start_frame();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(0, 0);
    check_frame("restart_ignored");
    check("overflow_sticky", credit_err, 1);

    // Push into a full downstream FIFO
    do_reset(1);
    in_empty = 1'b0;
    start_frame();
    repeat (3) tick();
    out_full = 1'b1;
    tick();
    out_full = 1'b0;
    check("full_push_err", credit_err, 1);
    do_reset(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
